// File: rtl/seq_divider_ctrl_if.sv
// Handshake/result bundle for seq_divider_ctrl.
// master: upstream drives start/operands; slave: divider drives results.
interface seq_divider_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
`ifdef DIV_ABORT_EN
  logic             abort;
`endif

  modport master (
`ifdef DIV_ABORT_EN
    output abort,
`endif
    output start,
    output dividend,
    output divisor,
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
`ifdef DIV_ABORT_EN
    input  abort,
`endif
    input  start,
    input  dividend,
    input  divisor,
    output busy,
    output done,
    output quotient,
    output remainder,
    output div_by_zero
  );
endinterface

// File: rtl/seq_divider_ctrl.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Ports: clk, rst (async, active-low), bus (seq_divider_ctrl_if.slave):
//   start/dividend/divisor in; busy/done/quotient/remainder/div_by_zero
//   out, all registered. Optional DIV_ABORT_EN adds bus.abort, which
//   cancels a running division without touching the held results.
module seq_divider_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  seq_divider_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] m_r;
  logic [CW-1:0]    cnt;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rem_r;
  logic             dbz_r;

  logic [WIDTH:0]   s;
  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] a_nx;
  logic [WIDTH-1:0] q_nx;
  logic             abort_req;

`ifdef DIV_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  // Trial subtraction; a borrow out of the top bit means restore.
  always_comb begin
    s    = {a_r, q_r[WIDTH-1]};
    t    = s - {1'b0, m_r};
    a_nx = s[WIDTH-1:0];
    q_nx = {q_r[WIDTH-2:0], 1'b0};
    if (!t[WIDTH]) begin
      a_nx = t[WIDTH-1:0];
      q_nx = {q_r[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      a_r    <= '0;
      q_r    <= '0;
      m_r    <= '0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      quo_r  <= '0;
      rem_r  <= '0;
      dbz_r  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            busy_r <= 1'b1;
            if (bus.divisor != '0) begin
              state <= CALC;
              a_r   <= '0;
              q_r   <= bus.dividend;
              m_r   <= bus.divisor;
              cnt   <= CW'(WIDTH);
            end else begin
              state  <= DONE;
              done_r <= 1'b1;
              quo_r  <= '1;
              rem_r  <= bus.dividend;
              dbz_r  <= 1'b1;
            end
          end
        end
        CALC: begin
          if (abort_req) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else begin
            a_r <= a_nx;
            q_r <= q_nx;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              state  <= DONE;
              done_r <= 1'b1;
              quo_r  <= q_nx;
              rem_r  <= a_nx;
              dbz_r  <= 1'b0;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quo_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_seq_divider_ctrl.sv
// Self-checking bench for seq_divider_ctrl (WIDTH=4).
// Cycle model in arithmetic terms plus directed literal checks.
module tb_seq_divider_ctrl;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_divider_ctrl_if #(.WIDTH(W)) bus ();

  seq_divider_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passed = 0;
  bit chk_en = 1'b0;

  task automatic check(
    input string name,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference: an accepted job finishes WIDTH edges after the start
  // edge with q = a/b, r = a%b; divide by zero finishes at once.
  logic         m_busy = 0;
  logic         m_done = 0;
  logic         m_z    = 0;
  logic [W-1:0] m_q    = '0;
  logic [W-1:0] m_r    = '0;
  int           m_left = 0;
  int           p_dd   = 0;
  int           p_dv   = 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_done = 0; m_z = 0;
      m_q = '0; m_r = '0; m_left = 0;
    end else if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else if (m_left > 0) begin
`ifdef DIV_ABORT_EN
      if (bus.abort) begin
        m_left = 0;
        m_busy = 0;
      end else
`endif
      begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1;
          m_q = W'(p_dd / p_dv);
          m_r = W'(p_dd % p_dv);
          m_z = 0;
        end
      end
    end else if (bus.start) begin
      m_busy = 1;
      if (bus.divisor == 0) begin
        m_done = 1;
        m_q = '1;
        m_r = bus.dividend;
        m_z = 1;
      end else begin
        p_dd = int'(bus.dividend);
        p_dv = int'(bus.divisor);
        m_left = W;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      check("cycle",
        32'({bus.busy, bus.done, bus.quotient,
             bus.remainder, bus.div_by_zero}),
        32'({m_busy, m_done, m_q, m_r, m_z}));
  end

  task automatic run(
    input int dd, input int dv,
    input int eq, input int er, input int ez,
    input int lat,
    input bit hold = 0,
    input int hdd = 0, input int hdv = 0
  );
    int n;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = W'(dd);
    bus.divisor  = W'(dv);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) begin
        check("busy_next", 32'(bus.busy), 32'd1);
        if (hold) begin
          bus.dividend = W'(hdd);
          bus.divisor  = W'(hdv);
        end else begin
          bus.start = 1'b0;
        end
      end
      if (bus.done) break;
    end
    bus.start = 1'b0;
    check("latency", 32'(n), 32'(lat));
    check("quotient", 32'(bus.quotient), 32'(eq));
    check("remainder", 32'(bus.remainder), 32'(er));
    check("dbz", 32'(bus.div_by_zero), 32'(ez));
    @(negedge clk);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
`ifdef DIV_ABORT_EN
    bus.abort    = 1'b0;
`endif
    #1 rst = 1'b0;
    #1;
    check("reset",
      32'({bus.busy, bus.done, bus.quotient,
           bus.remainder, bus.div_by_zero}), 32'd0);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run(13, 3, 4, 1, 0, 5);
    repeat (3) @(negedge clk);
    check("hold_q", 32'(bus.quotient), 32'd4);
    check("hold_r", 32'(bus.remainder), 32'd1);

    run(15, 1, 15, 0, 0, 5);
    run(7, 9, 0, 7, 0, 5);
    run(0, 5, 0, 0, 0, 5);
    run(15, 15, 1, 0, 0, 5);
    run(9, 0, 15, 9, 1, 1);
    run(6, 2, 3, 0, 0, 5);

    run(13, 3, 4, 1, 0, 5, 1'b1, 2, 1);
    repeat (3) @(negedge clk);
    check("no_rerun_done", 32'(bus.done), 32'd0);
    check("no_rerun_q", 32'(bus.quotient), 32'd4);

    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 4'd13;
    bus.divisor  = 4'd3;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    #1;
    check("mid_reset",
      32'({bus.busy, bus.done, bus.quotient,
           bus.remainder, bus.div_by_zero}), 32'd0);
    repeat (3) @(negedge clk);
    check("reset_no_done", 32'(bus.done), 32'd0);
    rst = 1'b1;
    run(10, 4, 2, 2, 0, 5);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) run(a, b, 15, a, 1, 1);
        else run(a, b, a / b, a % b, 0, 5);
      end
    end

`ifdef DIV_ABORT_EN
    run(6, 4, 1, 2, 0, 5);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 4'd13;
    bus.divisor  = 4'd3;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); #1 bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_q", 32'(bus.quotient), 32'd1);
    check("abort_r", 32'(bus.remainder), 32'd2);
    repeat (6) @(negedge clk);
    check("abort_no_done", 32'(bus.done), 32'd0);
    run(13, 3, 4, 1, 0, 5);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/seq_divider_ctrl.md
Name: seq_divider_ctrl

Overview:
- Sequential unsigned restoring divider: controller FSM plus A/Q/M working registers.
- Accepts dividend/divisor on a start handshake and iterates one quotient bit per clock.
- Returns quotient, remainder and a divide-by-zero flag with a one-cycle done pulse.
- Upstream issues operands; this block sequences the load/shift/subtract steps and presents held results downstream.

Parameters:
- WIDTH, 4, operand/result width in bits (>=2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low (0 = reset)
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  unsigned dividend, captured on accepted start
- divisor  input  WIDTH  unsigned divisor, captured on accepted start
- busy  output  1  high in CALC and DONE
- done  output  1  one-cycle pulse, results valid
- quotient  output  WIDTH  registered quotient, held until next done
- remainder  output  WIDTH  registered remainder, held until next done
- div_by_zero  output  1  registered flag for the last completed operation, held until next done
- abort  input  1  present only with DIV_ABORT_EN

Behaviour:
- Reset (rst=0, async): state=IDLE; A, Q, M, count, busy, done, quotient, remainder and div_by_zero all 0.
- IDLE:
  - start=1 and divisor!=0: load A=0, Q=dividend, M=divisor, count=WIDTH; go to CALC.
  - start=1 and divisor==0: go directly to DONE; register quotient=all ones, remainder=dividend, div_by_zero=1.
- CALC, one iteration per clock:
  - Form S = {A, Q[WIDTH-1]}, WIDTH+1 bits; Q shifts left by 1.
  - T = S - {1'b0, M}, WIDTH+1 bits.
  - If T[WIDTH]==0: A=T[WIDTH-1:0] and the new Q[0]=1. Otherwise A=S[WIDTH-1:0] and the new Q[0]=0.
  - count decrements by 1.
  - On the edge that performs the iteration with count==1: go to DONE; register quotient=final Q, remainder=final A, div_by_zero=0.
- DONE: done=1 and busy=1 for exactly one cycle; next edge goes to IDLE.
- Latency, measured from the edge that samples start:
  - Normal operation: done is high in the cycle after the WIDTH-th following edge, i.e. WIDTH+1 edges total.
  - Divide by zero: done is high after 1 edge.
- Throughput: the next start is accepted in the cycle after done, i.e. in IDLE.
- start while busy: ignored, no queuing. dividend/divisor changes during CALC have no effect.
- Result outputs change only on the edge entering DONE; they are stable at all other times.
- dividend < divisor: quotient=0, remainder=dividend.
- divisor=1: quotient=dividend, remainder=0.
- dividend=0 (divisor!=0): quotient=0, remainder=0.
- Reset asserted mid-operation: immediate return to the reset state; no done pulse; results cleared to 0.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro: DIV_ABORT_EN.
- With the macro defined:
  - Adds the abort input.
  - abort=1 sampled in CALC: return to IDLE on that edge; no done pulse; quotient, remainder and div_by_zero keep their previous values.
  - abort in IDLE or DONE has no effect.
  - Same-cycle start and abort in IDLE: start wins.
- Without the macro: no abort port; CALC always runs to completion.

Test Plan:
- WIDTH=4, dividend=13, divisor=3, start for 1 cycle -> busy high next cycle; done after 5 edges; quotient=4, remainder=1, div_by_zero=0; outputs hold afterwards.
- Sweep at WIDTH=4: 15/1 -> q=15 r=0; 7/9 -> q=0 r=7; 0/5 -> q=0 r=0; 15/15 -> q=1 r=0; full 256-pair sweep matches a reference model.
- dividend=9, divisor=0 -> done after 1 edge; quotient=15, remainder=9, div_by_zero=1. A following 6/2 -> q=3 r=0 with div_by_zero=0.
- Start 13/3, then hold start=1 with 2/1 during CALC -> only the 13/3 result (q=4 r=1) appears; one done pulse; 2/1 is not run.
- Start 13/3, drive rst=0 after 2 edges -> all outputs 0 immediately, no done. After release, a new 10/4 gives q=2 r=2.
- DIV_ABORT_EN defined:
  - Finish 6/4 (q=1 r=2).
  - Start 13/3, assert abort in the second CALC cycle -> IDLE next edge, no done, outputs remain q=1 r=2.
  - Start 13/3 again -> q=4 r=1.
